shiftreg_serialin_rx: RTL and testbench
=======================================

SHIFTREG_SERIALIN_RX -- requirements
Module: shiftreg_serialin_rx

Interface
REQ-001 Parameter N, default 9, SHALL be the frame length in bits: one start bit plus N-1 data bits, with N >= 3.
REQ-002 Parameter STOP_CHECK, default 1, SHALL enable the stop-bit check (1 = check enabled, 0 = check disabled).
REQ-003 clk  input  1  SHALL be the clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 sin  input  1  SHALL be the serial line, sampled one bit per clk; the line idles high.
REQ-006 dout  output  N-1  SHALL carry the received data word, MSB first on the line.
REQ-007 dout_valid  output  1  SHALL indicate that dout holds an unread word.
REQ-008 dout_ready  input  1  SHALL be the consumer acknowledge; a word transfers when dout_valid and dout_ready are both high.
REQ-009 busy  output  1  SHALL be high whenever the FSM is not in IDLE.
REQ-010 frame_err  output  1  SHALL be a one-cycle pulse on a bad stop bit.
REQ-011 overrun  output  1  SHALL be a sticky flag set when a completed word is lost; it clears only on reset.

Function
REQ-012 The FSM SHALL have states IDLE, DATA and STOP (STOP is used only when STOP_CHECK=1).
REQ-013 In IDLE, sin=0 sampled at edge t SHALL be taken as the start bit and SHALL move the FSM to DATA, clearing the bit counter.
REQ-014 In DATA, the block SHALL shift sin into the LSB of a shift register on each edge (shreg <= {shreg[N-3:0], sin}) for exactly N-1 edges, t+1 .. t+N-1.
REQ-015 The bit counter SHALL be $clog2(N) bits wide and SHALL count from 0 to N-2; at N-2 the FSM SHALL leave DATA.
REQ-016 With STOP_CHECK=1, the bit at edge t+N SHALL be the stop bit: sin=1 SHALL complete the frame, and sin=0 SHALL pulse frame_err for one cycle and discard the word; the FSM SHALL then return to IDLE.
REQ-017 With STOP_CHECK=0, the frame SHALL complete at the last data edge and the FSM SHALL return to IDLE.
REQ-018 On frame completion, the shift register SHALL be copied into the dout holding register and dout_valid SHALL be set; dout_valid SHALL be visible in the cycle after the completing edge.
REQ-019 dout and dout_valid SHALL stay stable until a handshake occurs; after a handshake edge with no new completion, dout_valid SHALL clear.
REQ-020 If a completion and a handshake occur on the same edge, the new word SHALL load and dout_valid SHALL stay 1.
REQ-021 If a completion occurs while dout_valid=1 and dout_ready=0, the new word SHALL be dropped, the old dout SHALL be kept, and overrun SHALL be set.
REQ-022 The block SHALL accept back-to-back frames: a start bit sampled on the edge immediately after the stop edge (or after the last data edge when STOP_CHECK=0) SHALL be accepted.
REQ-023 sin=1 in IDLE SHALL leave all state unchanged; no glitch filtering or oversampling is performed.
REQ-024 busy SHALL be a registered decode of state != IDLE.

Reset
REQ-025 Asserting reset SHALL clear immediately: state to IDLE, counter to 0, shift register to 0, dout to 0, dout_valid to 0, frame_err to 0, overrun to 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no dout_valid and no frame_err; the first edge after reset release SHALL be sampled in IDLE.

Structure
REQ-027 The state encoding (IDLE=0, DATA=1, STOP=2) and the idle-level constant (1) SHALL reside in the shared package shiftreg_pkg, alongside the transmitter constants.
REQ-028 The block SHALL be a single module with no sub-module; the counter, FSM and holding register are inline.

Verification
REQ-029 With N=9 and dout_ready=1, the bits 0,1,0,1,0,0,1,0,1,1 applied from edge t SHALL give dout=8'hA5 and a one-cycle dout_valid after edge t+9, with frame_err=0.
REQ-030 Two back-to-back frames carrying 8'h3C and 8'hFF with no idle gap SHALL produce two valid words in order, with busy continuously high across both.
REQ-031 A frame of 8'h81 with stop bit 0 SHALL pulse frame_err once, leave dout_valid low and keep dout unchanged.
REQ-032 With dout_ready=0, frames 8'h11 then 8'h22 SHALL leave dout=8'h11 and set overrun=1; raising dout_ready for one cycle SHALL then clear dout_valid.
REQ-033 Asserting reset at edge t+4 of a frame, then sending 8'h5A, SHALL give no output from the aborted frame and then dout=8'h5A.
REQ-034 With STOP_CHECK=0 and N=5, the bits 0,1,1,0,1 SHALL give dout=4'hD, with dout_valid visible after edge t+4.

Source files
------------

// File: rtl/shiftreg_pkg.sv
// Shared constants for the shift-register serial receiver and transmitter.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam int   TX_DEFAULT_N   = 9;
  localparam logic TX_START_LEVEL = 1'b0;
  localparam logic TX_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/shiftreg_serialin_rx.sv
// Serial-in frame receiver: start bit, N-1 data bits MSB first, optional stop bit,
// with a single-entry valid/ready holding register and sticky overrun flag.
module shiftreg_serialin_rx
  import shiftreg_pkg::*;
#(
  parameter int N          = 9,
  parameter int STOP_CHECK = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  output logic [N-2:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(N);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-2:0]   shreg_q, shreg_d;
  logic [N-2:0]   dout_q;
  logic           valid_q;
  logic           busy_q;
  logic           ferr_q, ferr_d;
  logic           ovr_q;
  logic           complete;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    ferr_d   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (sin != IDLE_LEVEL) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shreg_d = {shreg_q[N-3:0], sin};
        if (cnt_q == CW'(N-2)) begin
          if (STOP_CHECK != 0) begin
            state_d = STOP;
          end else begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        state_d = IDLE;
        if (sin == IDLE_LEVEL) complete = 1'b1;
        else                   ferr_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      ferr_q  <= ferr_d;
      // Covers both old and new state so busy stays high across back-to-back frames.
      busy_q  <= (state_q != IDLE) || (state_d != IDLE);
      if (complete) begin
        if (!valid_q || dout_ready) begin
          dout_q  <= shreg_d;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && dout_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_shiftreg_serialin_rx.sv
// Directed bench for shiftreg_serialin_rx: N=9 with stop check, N=5 without.
module tb_shiftreg_serialin_rx;

  logic       clk;
  logic       reset;
  logic       sin, sin5;
  logic       dout_ready, dout_ready5;
  logic [7:0] dout;
  logic [3:0] dout5;
  logic       dout_valid, dout_valid5;
  logic       busy, busy5;
  logic       frame_err, frame_err5;
  logic       overrun, overrun5;

  int unsigned errors = 0;
  int unsigned checks = 0;

  shiftreg_serialin_rx #(.N(9), .STOP_CHECK(1)) dut9 (
    .clk(clk), .reset(reset), .sin(sin), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  shiftreg_serialin_rx #(.N(5), .STOP_CHECK(0)) dut5 (
    .clk(clk), .reset(reset), .sin(sin5), .dout(dout5), .dout_valid(dout_valid5),
    .dout_ready(dout_ready5), .busy(busy5), .frame_err(frame_err5), .overrun(overrun5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bits go out start, d[7]..d[0], stop.
  task automatic send_frame9(input logic [7:0] d, input logic stopb, input bit chk_busy);
    logic [9:0] bits;
    bits = {1'b0, d, stopb};
    for (int i = 9; i >= 0; i--) begin
      sin = bits[i];
      tick();
      if (chk_busy) chk("busy_in_frame", 32'(busy), 32'd1);
    end
    sin = 1'b1;
  endtask

  initial begin
    logic [4:0] bits5;
    reset       = 1'b1;
    sin         = 1'b1;
    sin5        = 1'b1;
    dout_ready  = 1'b1;
    dout_ready5 = 1'b1;
    repeat (2) tick();
    chk("rst_dout",    32'(dout),       32'h0);
    chk("rst_valid",   32'(dout_valid), 32'd0);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_ferr",    32'(frame_err),  32'd0);
    chk("rst_overrun", 32'(overrun),    32'd0);
    reset = 1'b0;
    repeat (2) tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // A5 with good stop, ready held high
    send_frame9(8'hA5, 1'b1, 1'b1);
    chk("a5_dout",  32'(dout),       32'hA5);
    chk("a5_valid", 32'(dout_valid), 32'd1);
    chk("a5_ferr",  32'(frame_err),  32'd0);
    tick();
    chk("a5_valid_clr", 32'(dout_valid), 32'd0);
    chk("a5_busy_clr",  32'(busy),       32'd0);

    // Back-to-back 3C then FF, busy checked on every edge
    send_frame9(8'h3C, 1'b1, 1'b1);
    chk("b2b_dout0",  32'(dout),       32'h3C);
    chk("b2b_valid0", 32'(dout_valid), 32'd1);
    send_frame9(8'hFF, 1'b1, 1'b1);
    chk("b2b_dout1",  32'(dout),       32'hFF);
    chk("b2b_valid1", 32'(dout_valid), 32'd1);
    tick();
    chk("b2b_valid_clr", 32'(dout_valid), 32'd0);

    // Bad stop bit
    send_frame9(8'h81, 1'b0, 1'b0);
    chk("ferr_pulse", 32'(frame_err),  32'd1);
    chk("ferr_valid", 32'(dout_valid), 32'd0);
    chk("ferr_dout",  32'(dout),       32'hFF);
    tick();
    chk("ferr_one_cycle", 32'(frame_err), 32'd0);
    chk("ferr_dout_kept", 32'(dout),      32'hFF);

    // Overrun with consumer stalled
    dout_ready = 1'b0;
    send_frame9(8'h11, 1'b1, 1'b0);
    chk("ovr_dout0",   32'(dout),    32'h11);
    chk("ovr_flag0",   32'(overrun), 32'd0);
    send_frame9(8'h22, 1'b1, 1'b0);
    chk("ovr_dout1",   32'(dout),       32'h11);
    chk("ovr_valid1",  32'(dout_valid), 32'd1);
    chk("ovr_flag1",   32'(overrun),    32'd1);
    tick();
    chk("ovr_stable",  32'(dout), 32'h11);
    dout_ready = 1'b1;
    tick();
    chk("ovr_hs_clr",  32'(dout_valid), 32'd0);
    chk("ovr_sticky",  32'(overrun),    32'd1);

    // Reset mid-frame at edge t+4, then a clean 5A frame
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy_async", 32'(busy),    32'd0);
    chk("abort_ovr_async",  32'(overrun), 32'd0);
    tick();
    reset = 1'b0;
    sin   = 1'b1;
    repeat (12) tick();
    chk("abort_valid", 32'(dout_valid), 32'd0);
    chk("abort_ferr",  32'(frame_err),  32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    send_frame9(8'h5A, 1'b1, 1'b0);
    chk("post_rst_dout",  32'(dout),       32'h5A);
    chk("post_rst_valid", 32'(dout_valid), 32'd1);
    tick();

    // N=5 without stop check: 0,1,1,0,1 -> D after edge t+4
    bits5 = 5'b01101;
    for (int i = 4; i >= 1; i--) begin
      sin5 = bits5[i];
      tick();
    end
    chk("n5_valid_early", 32'(dout_valid5), 32'd0);
    sin5 = bits5[0];
    tick();
    sin5 = 1'b1;
    chk("n5_dout",  32'(dout5),       32'hD);
    chk("n5_valid", 32'(dout_valid5), 32'd1);
    chk("n5_ferr",  32'(frame_err5),  32'd0);
    tick();
    chk("n5_valid_clr", 32'(dout_valid5), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
